alu_instr_sequencer: RTL



---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_instr_sequencer_if.sv | 39 +++
 rtl/alu_seq_decode.sv | 23 ++
 rtl/alu_instr_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared states, opcodes, IR field positions and op-class helpers
package alu_seq_pkg;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_NOT = 5'd4;
  localparam logic [4:0] OP_MUL = 5'd5;
  localparam logic [4:0] OP_DIV = 5'd6;
  localparam logic [4:0] OP_SHR = 5'd7;
  localparam logic [4:0] OP_SHL = 5'd8;
  localparam logic [4:0] OP_ROR = 5'd9;
  localparam logic [4:0] OP_ROL = 5'd10;
  localparam logic [4:0] OP_XOR = 5'd11;
  localparam logic [4:0] OP_NEG = 5'd12;

  typedef enum logic [1:0] {
    CLS_BINARY = 2'd0,
    CLS_UNARY  = 2'd1,
    CLS_MULDIV = 2'd2
  } op_class_e;

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NOT) || (op == OP_NEG);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// rtl/alu_instr_sequencer_if.sv - control bus between the sequencer and the Mini SRC datapath
interface alu_seq_ctrl_if;
  logic        mem_ready;
  logic [31:0] w_IR;
  logic        s_PC;
  logic        s_Zlow;
  logic        s_Zhigh;
  logic        s_MDR;
  logic        s_Rout;
  logic [3:0]  rsel_out;
  logic        e_Rin;
  logic [3:0]  rsel_in;
  logic        e_MAR;
  logic        e_Z;
  logic        e_PC;
  logic        e_MDR;
  logic        e_IR;
  logic        e_Y;
  logic        e_HI;
  logic        e_LO;
  logic        e_alu;
  logic        w_IncPC;
  logic        w_read;
  logic [5:0]  opcode;

  modport master (
    input  mem_ready, w_IR,
    output s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout, rsel_out, e_Rin, rsel_in,
           e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
           w_IncPC, w_read, opcode
  );

  modport slave (
    output mem_ready, w_IR,
    input  s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout, rsel_out, e_Rin, rsel_in,
           e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
           w_IncPC, w_read, opcode
  );
endinterface

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - classifies the IR opcode field and flags opcodes beyond MAX_OP
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int MAX_OP = 12
) (
  input  logic [4:0] op,
  output op_class_e  op_class,
  output logic       op_illegal
);

  assign op_illegal = (int'(op) > MAX_OP);

  always_comb begin
    op_class = CLS_BINARY;
    if (is_unary(op)) begin
      op_class = CLS_UNARY;
    end else if (is_muldiv(op)) begin
      op_class = CLS_MULDIV;
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - fetch/decode/execute control FSM for register-to-register ALU instructions
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MAX_OP = 12
) (
  input  logic             w_clock,
  input  logic             w_clear_n,
  input  logic             run,
  alu_seq_ctrl_if.master   ctl,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       op;
  logic [3:0]       ra, rb, rc;
  op_class_e        op_class;
  logic             op_illegal;
  logic             retire;
  logic             unused_ir_low;

  assign op = ctl.w_IR[OP_HI:OP_LO];
  assign ra = ctl.w_IR[RA_HI:RA_LO];
  assign rb = ctl.w_IR[RB_HI:RB_LO];
  assign rc = ctl.w_IR[RC_HI:RC_LO];
  assign unused_ir_low = ^ctl.w_IR[RC_LO-1:0];

  alu_seq_decode #(.MAX_OP(MAX_OP)) u_decode (
    .op         (op),
    .op_class   (op_class),
    .op_illegal (op_illegal)
  );

  // Last execute step of each class writes back and retires the instruction.
  always_comb begin
    case (state_q)
      ST_T4:   retire = (op_class == CLS_UNARY);
      ST_T5:   retire = (op_class == CLS_BINARY);
      ST_T6:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (ctl.mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (op_illegal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ST_T6;
      ST_T6:   state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (retire) begin
      count_d = count_q + 1'b1;
      state_d = run ? ST_T0 : ST_IDLE;
    end
  end

  always_ff @(posedge w_clock) begin
    if (!w_clear_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    ctl.s_PC     = 1'b0;
    ctl.s_Zlow   = 1'b0;
    ctl.s_Zhigh  = 1'b0;
    ctl.s_MDR    = 1'b0;
    ctl.s_Rout   = 1'b0;
    ctl.rsel_out = 4'd0;
    ctl.e_Rin    = 1'b0;
    ctl.rsel_in  = 4'd0;
    ctl.e_MAR    = 1'b0;
    ctl.e_Z      = 1'b0;
    ctl.e_PC     = 1'b0;
    ctl.e_MDR    = 1'b0;
    ctl.e_IR     = 1'b0;
    ctl.e_Y      = 1'b0;
    ctl.e_HI     = 1'b0;
    ctl.e_LO     = 1'b0;
    ctl.e_alu    = 1'b0;
    ctl.w_IncPC  = 1'b0;
    ctl.w_read   = 1'b0;
    ctl.opcode   = 6'd0;
    case (state_q)
      ST_T0: begin
        ctl.s_PC    = 1'b1;
        ctl.e_MAR   = 1'b1;
        ctl.w_IncPC = 1'b1;
        ctl.e_Z     = 1'b1;
      end
      ST_T1: begin
        ctl.s_Zlow = 1'b1;
        ctl.e_PC   = 1'b1;
        ctl.w_read = 1'b1;
        ctl.e_MDR  = 1'b1;
      end
      ST_T2: begin
        ctl.s_MDR = 1'b1;
        ctl.e_IR  = 1'b1;
      end
      ST_T3: begin
        if (!op_illegal) begin
          ctl.opcode = {1'b0, op};
          ctl.s_Rout = 1'b1;
          if (op_class == CLS_UNARY) begin
            ctl.rsel_out = rb;
            ctl.e_alu    = 1'b1;
            ctl.e_Z      = 1'b1;
          end else begin
            ctl.rsel_out = (op_class == CLS_MULDIV) ? ra : rb;
            ctl.e_Y      = 1'b1;
          end
        end
      end
      ST_T4: begin
        ctl.opcode = {1'b0, op};
        if (op_class == CLS_UNARY) begin
          ctl.s_Zlow  = 1'b1;
          ctl.e_Rin   = 1'b1;
          ctl.rsel_in = ra;
        end else begin
          ctl.s_Rout   = 1'b1;
          ctl.rsel_out = (op_class == CLS_MULDIV) ? rb : rc;
          ctl.e_alu    = 1'b1;
          ctl.e_Z      = 1'b1;
        end
      end
      ST_T5: begin
        ctl.opcode = {1'b0, op};
        ctl.s_Zlow = 1'b1;
        if (op_class == CLS_MULDIV) begin
          ctl.e_LO = 1'b1;
        end else begin
          ctl.e_Rin   = 1'b1;
          ctl.rsel_in = ra;
        end
      end
      ST_T6: begin
        ctl.opcode  = {1'b0, op};
        ctl.s_Zhigh = 1'b1;
        ctl.e_HI    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule
